name_component_serializer: RTL and testbench

//  Transmit side of the FIB name-component interface. Accepts one whole NDN name
//  (up to MAX_NAME_LENGTH 32-bit components) in parallel and streams it into the

---
 rtl/name_component_serializer_if.sv | 30 +++
 rtl/name_component_serializer.sv | 132 +++++++++++++
 tb/tb_name_component_serializer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/name_component_serializer_if.sv
// Name-load and component-stream signals for name_component_serializer.
// master = serializer side, slave = name source / lookup pipeline side.
interface name_component_serializer_if #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int LEN_W           = 4
);
  logic                                 load_valid_in;
  logic                                 load_ready_out;
  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] load_name_in;
  logic [LEN_W-1:0]                     load_len_in;
  logic [WORD_SIZE-1:0]                 name_component_out;
  logic                                 comp_valid_out;
  logic                                 comp_ready_in;
  logic                                 comp_last_out;
  logic [15:0]                          names_sent_out;
  logic                                 len_err_out;

  modport master (
    input  load_valid_in, load_name_in, load_len_in, comp_ready_in,
    output load_ready_out, name_component_out, comp_valid_out, comp_last_out,
           names_sent_out, len_err_out
  );

  modport slave (
    output load_valid_in, load_name_in, load_len_in, comp_ready_in,
    input  load_ready_out, name_component_out, comp_valid_out, comp_last_out,
           names_sent_out, len_err_out
  );
endinterface

// File: rtl/name_component_serializer.sv
// Streams one parallel NDN name into the FIB pipeline, highest component index first.
// Optional macro NAME_SER_PAD_EN: pad every name to MAX_NAME_LENGTH components (zeros above len).
module name_component_serializer #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int LEN_W           = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  name_component_serializer_if.master   bus
);

  localparam int                GAP_W       = $clog2(GAP_CYCLES + 2);
  localparam logic [LEN_W-1:0]  LP_MAX_LEN  = LEN_W'(MAX_NAME_LENGTH);
  localparam logic [GAP_W-1:0]  LP_GAP_LAST = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] r_name;
  logic [LEN_W-1:0]                     r_idx;
  logic [GAP_W-1:0]                     r_gap_cnt;
  logic [15:0]                          r_names_sent;
  logic                                 r_len_err;
`ifdef NAME_SER_PAD_EN
  logic [LEN_W-1:0]                     r_len;
`endif

  logic                 w_len_ok;
  logic                 w_accept;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_ready;
  logic                 w_valid;
  logic [LEN_W-1:0]     w_idx_start;
  logic [WORD_SIZE-1:0] w_word;

  assign w_len_ok = (bus.load_len_in != '0) && (bus.load_len_in <= LP_MAX_LEN);

`ifdef NAME_SER_PAD_EN
  assign w_idx_start = LEN_W'(MAX_NAME_LENGTH - 1);
`else
  assign w_idx_start = bus.load_len_in - LEN_W'(1);
`endif

  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < MAX_NAME_LENGTH; i++) begin
      if (r_idx == LEN_W'(i)) w_word = r_name[i*WORD_SIZE +: WORD_SIZE];
    end
`ifdef NAME_SER_PAD_EN
    // Padding slots above the real length go out as zero words.
    if (r_idx >= r_len) w_word = '0;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    w_last      = (r_state == S_SEND) && (r_idx == '0);
    case (r_state)
      S_IDLE: begin
        // Ready is masked during reset so no handshake completes in that cycle.
        w_ready  = ~rst_in;
        w_accept = bus.load_valid_in & w_ready;
        if (w_accept && w_len_ok) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_valid = 1'b1;
        w_xfer  = bus.comp_ready_in;
        if (w_xfer && w_last) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == LP_GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_name       <= '0;
      r_idx        <= '0;
      r_gap_cnt    <= '0;
      r_names_sent <= '0;
      r_len_err    <= 1'b0;
`ifdef NAME_SER_PAD_EN
      r_len        <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_len_ok) begin
          r_name <= bus.load_name_in;
          r_idx  <= w_idx_start;
`ifdef NAME_SER_PAD_EN
          r_len  <= bus.load_len_in;
`endif
        end else begin
          r_len_err <= 1'b1;
        end
      end
      if (w_xfer) begin
        if (w_last) begin
          r_names_sent <= r_names_sent + 16'd1;
          r_gap_cnt    <= '0;
        end else begin
          r_idx <= r_idx - LEN_W'(1);
        end
      end
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  assign bus.load_ready_out     = w_ready;
  assign bus.comp_valid_out     = w_valid;
  assign bus.comp_last_out      = w_last;
  assign bus.name_component_out = w_valid ? w_word : '0;
  assign bus.names_sent_out     = r_names_sent;
  assign bus.len_err_out        = r_len_err;

endmodule

// File: tb/tb_name_component_serializer.sv
// Directed bench for name_component_serializer: vector table plus reset-abort and gap-timing sequences.
// Three instances (GAP_CYCLES 0/1/2) share stimulus; most checks target the GAP_CYCLES=1 instance.
module tb_name_component_serializer;
  localparam int WS = 32;
  localparam int ML = 8;
  localparam int LW = 4;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             valid  = 1'b0;
  logic             cready = 1'b0;
  logic [ML*WS-1:0] name_r = '0;
  logic [LW-1:0]    len_r  = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  name_component_serializer_if #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_W(LW)) if0 ();
  name_component_serializer_if #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_W(LW)) if1 ();
  name_component_serializer_if #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_W(LW)) if2 ();

  assign if0.load_valid_in = valid;
  assign if0.load_name_in  = name_r;
  assign if0.load_len_in   = len_r;
  assign if0.comp_ready_in = cready;
  assign if1.load_valid_in = valid;
  assign if1.load_name_in  = name_r;
  assign if1.load_len_in   = len_r;
  assign if1.comp_ready_in = cready;
  assign if2.load_valid_in = valid;
  assign if2.load_name_in  = name_r;
  assign if2.load_len_in   = len_r;
  assign if2.comp_ready_in = cready;

  name_component_serializer #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_W(LW), .GAP_CYCLES(0))
    dut0 (.clk_in(clk), .rst_in(rst), .bus(if0));
  name_component_serializer #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_W(LW), .GAP_CYCLES(1))
    dut1 (.clk_in(clk), .rst_in(rst), .bus(if1));
  name_component_serializer #(.WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .LEN_W(LW), .GAP_CYCLES(2))
    dut2 (.clk_in(clk), .rst_in(rst), .bus(if2));

  logic [2:0] v_arr;
  logic [2:0] l_arr;
  logic [15:0] sent_arr [3];
  assign v_arr = {if2.comp_valid_out, if1.comp_valid_out, if0.comp_valid_out};
  assign l_arr = {if2.comp_last_out, if1.comp_last_out, if0.comp_last_out};
  assign sent_arr[0] = if0.names_sent_out;
  assign sent_arr[1] = if1.names_sent_out;
  assign sent_arr[2] = if2.names_sent_out;

  // Gap-timing monitor: negedge index of first last-transfer and of second name start.
  bit   mon_en = 1'b0;
  int   ncyc   = 0;
  int   last_at [3];
  int   start2_at [3];
  int   nstarts [3];
  logic [2:0] pv = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      ncyc = ncyc + 1;
      for (int d = 0; d < 3; d++) begin
        if (v_arr[d] && !pv[d]) begin
          nstarts[d] = nstarts[d] + 1;
          if (nstarts[d] == 2) start2_at[d] = ncyc;
        end
        if (v_arr[d] && cready && l_arr[d] && last_at[d] < 0) last_at[d] = ncyc;
      end
      pv = v_arr;
    end
  end

  typedef struct {
    logic [LW-1:0] len;
    logic [31:0]   base;
    bit            toggle;
    int            exp_n;
    logic [31:0]   exp_first;
    logic [15:0]   exp_sent;
    bit            exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [ML*WS-1:0] fill(input logic [31:0] base);
    logic [ML*WS-1:0] f;
    f = '0;
    for (int i = 0; i < ML; i++) f[i*WS +: WS] = base + 32'(i);
    return f;
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (!if1.load_ready_out && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!if1.load_ready_out) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int          n_x, k, idx, n_model;
    bit          done, pheld;
    logic [31:0] pw, expw;
    logic        pl;
    wait_ready();
    name_r = fill(v.base);
    len_r  = v.len;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    if (v.exp_n == 0) begin
      chk("err_no_valid", 32'(if1.comp_valid_out), 32'd0);
      chk("err_ready", 32'(if1.load_ready_out), 32'd1);
      chk("err_flag", 32'(if1.len_err_out), 32'(v.exp_err));
      chk("err_sent", 32'(if1.names_sent_out), 32'(v.exp_sent));
      @(negedge clk);
      chk("err_no_valid2", 32'(if1.comp_valid_out), 32'd0);
      return;
    end
`ifdef NAME_SER_PAD_EN
    n_model = ML;
`else
    n_model = int'(v.len);
`endif
    chk("latency_valid", 32'(if1.comp_valid_out), 32'd1);
    n_x = 0; k = 0; done = 0; pheld = 0; pw = '0; pl = 1'b0;
    while (!done && k < 64) begin
      cready = v.toggle ? ((k % 2) == 1) : 1'b1;
      if (pheld) begin
        chk("hold_word", if1.name_component_out, pw);
        chk("hold_last", 32'(if1.comp_last_out), 32'(pl));
      end
      if (!if1.comp_valid_out) begin
        chk("valid_mid_name", 32'd0, 32'd1);
        done = 1;
      end else if (cready) begin
        idx  = n_model - 1 - n_x;
        expw = (idx < int'(v.len)) ? v.base + 32'(idx) : 32'd0;
        if (n_x == 0) chk("first_word", if1.name_component_out, v.exp_first);
        chk("word", if1.name_component_out, expw);
        chk("last_flag", 32'(if1.comp_last_out), 32'(idx == 0));
        n_x++;
        pheld = 0;
        if (idx <= 0) done = 1;
      end else begin
        pheld = 1;
        pw    = if1.name_component_out;
        pl    = if1.comp_last_out;
      end
      k++;
      @(negedge clk);
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    cready = 1'b1;
    chk("xfer_count", 32'(n_x), 32'(v.exp_n));
    chk("send_cycles", 32'(k), 32'(v.toggle ? 2 * v.exp_n : v.exp_n));
    chk("gap_ready", 32'(if1.load_ready_out), 32'd0);
    chk("gap_valid", 32'(if1.comp_valid_out), 32'd0);
    chk("names_sent", 32'(if1.names_sent_out), 32'(v.exp_sent));
    chk("len_err", 32'(if1.len_err_out), 32'(v.exp_err));
    @(negedge clk);
    chk("ready_after_gap", 32'(if1.load_ready_out), 32'd1);
  endtask

  initial begin
    int n, k;
    vecs[0] = '{len: 4'd8, base: 32'hA0, toggle: 1'b0, exp_n: 8, exp_first: 32'hA7, exp_sent: 16'd1, exp_err: 1'b0};
    vecs[1] = '{len: 4'd8, base: 32'hA0, toggle: 1'b1, exp_n: 8, exp_first: 32'hA7, exp_sent: 16'd2, exp_err: 1'b0};
`ifdef NAME_SER_PAD_EN
    vecs[2] = '{len: 4'd3, base: 32'hC0, toggle: 1'b0, exp_n: 8, exp_first: 32'h0,  exp_sent: 16'd3, exp_err: 1'b0};
    vecs[5] = '{len: 4'd1, base: 32'hE0, toggle: 1'b1, exp_n: 8, exp_first: 32'h0,  exp_sent: 16'd4, exp_err: 1'b1};
`else
    vecs[2] = '{len: 4'd3, base: 32'hC0, toggle: 1'b0, exp_n: 3, exp_first: 32'hC2, exp_sent: 16'd3, exp_err: 1'b0};
    vecs[5] = '{len: 4'd1, base: 32'hE0, toggle: 1'b1, exp_n: 1, exp_first: 32'hE0, exp_sent: 16'd4, exp_err: 1'b1};
`endif
    vecs[3] = '{len: 4'd0, base: 32'hF0, toggle: 1'b0, exp_n: 0, exp_first: 32'h0,  exp_sent: 16'd3, exp_err: 1'b1};
    vecs[4] = '{len: 4'd9, base: 32'hF0, toggle: 1'b0, exp_n: 0, exp_first: 32'h0,  exp_sent: 16'd3, exp_err: 1'b1};

    // Reset cycle and post-reset values.
    @(negedge clk);
    chk("rst_cycle_ready", 32'(if1.load_ready_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(if1.load_ready_out), 32'd1);
    chk("rst_valid", 32'(if1.comp_valid_out), 32'd0);
    chk("rst_last", 32'(if1.comp_last_out), 32'd0);
    chk("rst_word", if1.name_component_out, 32'd0);
    chk("rst_sent", 32'(if1.names_sent_out), 32'd0);
    chk("rst_err", 32'(if1.len_err_out), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset after the third transfer of a full-length name.
    wait_ready();
    name_r = fill(32'hB0);
    len_r  = 4'd8;
    cready = 1'b1;
    valid  = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0; k = 0;
    while (n < 3 && k < 20) begin
      if (if1.comp_valid_out) n++;
      k++;
      @(negedge clk);
    end
    chk("abort_midname_valid", 32'(if1.comp_valid_out), 32'd1);
    chk("abort_pre_sent", 32'(if1.names_sent_out), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(if1.comp_valid_out), 32'd0);
    chk("abort_sent", 32'(if1.names_sent_out), 32'd0);
    chk("abort_ready_in_rst", 32'(if1.load_ready_out), 32'd0);
    chk("abort_err_cleared", 32'(if1.len_err_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(if1.load_ready_out), 32'd1);
    run_vec('{len: 4'd8, base: 32'hB0, toggle: 1'b0, exp_n: 8, exp_first: 32'hB7, exp_sent: 16'd1, exp_err: 1'b0});

    // Back-to-back full names on all three gap settings.
    for (int d = 0; d < 3; d++) begin
      last_at[d] = -1; start2_at[d] = -1; nstarts[d] = 0;
    end
    pv     = '0;
    ncyc   = 0;
    mon_en = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    cready = 1'b1;
    name_r = fill(32'hD0);
    len_r  = 4'd8;
    valid  = 1'b1;
    repeat (12) @(negedge clk);
    valid  = 1'b0;
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("gap%0d_next_start", d), 32'(start2_at[d] - last_at[d]), 32'(2 + d));
      chk($sformatf("gap%0d_names_sent", d), 32'(sent_arr[d]), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
